// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that shares one combinational 16-bit ALU
// between two requesters, with a valid/ready response tagged by requester id.
// Optional build macro ALU_ARB_STATS_EN adds saturating per-requester grant
// counters (grant_cnt0, grant_cnt1).
module alu_arbiter #(
    parameter int unsigned ALU_WAIT    = 1,
    parameter int unsigned MULDIV_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_ins,
    input  logic [15:0] alu_out,
    input  logic [15:0] alu_hi,
    input  logic [2:0]  alu_flags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_out,
    output logic [15:0] rsp_hi,
    output logic [2:0]  rsp_flags,
    output logic        rsp_err,
    output logic        busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0] grant_cnt0,
    output logic [15:0] grant_cnt1
`endif
);

    localparam int unsigned DW = 16;
    localparam int unsigned OW = 4;
    localparam int unsigned FW = 3;
    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic          rr;
    logic          id_q;
    logic          err_q;
    logic [CW-1:0] cnt;

    logic          grant0;
    logic          grant1;
    logic [DW-1:0] sel_a;
    logic [DW-1:0] sel_b;
    logic [OW-1:0] sel_op;
    logic          sel_ill;
    logic          sel_long;

    // Round-robin grant in IDLE and mux of the winning requester's operands
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && (!req1_valid || !rr)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
        sel_a    = grant1 ? req1_a  : req0_a;
        sel_b    = grant1 ? req1_b  : req0_b;
        sel_op   = grant1 ? req1_op : req0_op;
        sel_ill  = (sel_op == OW'(0)) || (sel_op > OW'(9));
        sel_long = (sel_op == OW'(3)) || (sel_op == OW'(4));
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Control FSM: accept one op, wait out its execution time, hold the response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr        <= 1'b0;
            id_q      <= 1'b0;
            err_q     <= 1'b0;
            cnt       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ins   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_out   <= '0;
            rsp_hi    <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        alu_a   <= sel_a;
                        alu_b   <= sel_b;
                        alu_ins <= sel_ill ? '0 : sel_op;
                        err_q   <= sel_ill;
                        id_q    <= grant1;
                        rr      <= grant0;
                        if (sel_ill) begin
                            cnt <= '0;
                        end else if (sel_long) begin
                            cnt <= CW'(MULDIV_WAIT - 1);
                        end else begin
                            cnt <= CW'(ALU_WAIT - 1);
                        end
                        busy    <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        if (err_q) begin
                            rsp_out   <= '0;
                            rsp_hi    <= '0;
                            rsp_flags <= FW'(0);
                        end else begin
                            rsp_out   <= alu_out;
                            rsp_hi    <= alu_hi;
                            rsp_flags <= alu_flags;
                        end
                        rsp_err   <= err_q;
                        rsp_id    <= id_q;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Saturating count of accepted ops per requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (grant0 && (grant_cnt0 != 16'hFFFF)) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (grant1 && (grant_cnt1 != 16'hFFFF)) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural ALU stub,
// directed scenarios and a randomized phase.
`timescale 1ns/1ps
module tb_alu_arbiter;

    localparam int unsigned AW = 1;
    localparam int unsigned MW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic [15:0] alu_a, alu_b, alu_out, alu_hi;
    logic [3:0]  alu_ins;
    logic [2:0]  alu_flags;
    logic        rsp_valid, rsp_id, rsp_err, busy;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_out, rsp_hi;
    logic [2:0]  rsp_flags;

    alu_arbiter #(.ALU_WAIT(AW), .MULDIV_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ins(alu_ins),
        .alu_out(alu_out), .alu_hi(alu_hi), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .rsp_hi(rsp_hi), .rsp_flags(rsp_flags),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural ALU: {flags, hi, out}; unknown op codes return junk on purpose
    function automatic logic [34:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] op);
        logic [31:0] p;
        logic [15:0] o;
        logic [15:0] h;
        o = '0;
        h = '0;
        case (op)
            4'd1: o = a + b;
            4'd2: o = a - b;
            4'd3: begin p = 32'(a) * 32'(b); o = p[15:0]; h = p[31:16]; end
            4'd4: if (b == 16'd0) begin o = 16'hFFFF; h = a; end
                  else begin o = a / b; h = a % b; end
            4'd5: o = a | b;
            4'd6: o = a & b;
            4'd7: o = ~a;
            4'd8: o = a ^ b;
            4'd9: o = (a < b) ? 16'd1 : ((a == b) ? 16'd0 : 16'd2);
            default: begin o = 16'hDEAD; h = 16'hBEEF; end
        endcase
        return {(o == 16'd0), o[15], (h != 16'd0), h, o};
    endfunction

    assign {alu_flags, alu_hi, alu_out} = alu_ref(alu_a, alu_b, alu_ins);

    function automatic logic is_ill(input logic [3:0] op);
        return (op == 4'd0) || (op > 4'd9);
    endfunction

    // Expected {err, flags, hi, out}
    function automatic logic [35:0] expect_of(input logic [15:0] a, input logic [15:0] b,
                                              input logic [3:0] op);
        if (is_ill(op)) return {1'b1, 35'd0};
        return {1'b0, alu_ref(a, b, op)};
    endfunction

    function automatic int wait_of(input logic [3:0] op);
        if (is_ill(op)) return 1;
        if (op == 4'd3 || op == 4'd4) return int'(MW);
        return int'(AW);
    endfunction

    typedef struct {
        logic        id;
        logic [35:0] exp;
        int          acc;
        int          lat;
    } ent_t;

    ent_t q[$];
    logic inflight = 1'b0;
    logic last_win = 1'b1;
    logic seen = 1'b0;
    logic prev_rv = 1'b0;
    int   hs0 = 0;
    int   hs1 = 0;

    // Monitor: arbitration model, scoreboard push on accept, pop on response
    always @(negedge clk) begin
        logic e0, e1;
        ent_t e;
        if (!rst_n) begin
            q.delete();
            inflight = 1'b0;
            last_win = 1'b1;
            seen     = 1'b0;
            prev_rv  = 1'b0;
        end else begin
            e0 = !inflight && req0_valid && (!req1_valid || last_win);
            e1 = !inflight && req1_valid && !e0;
            chk("req0_ready", 36'(req0_ready), 36'(e0));
            chk("req1_ready", 36'(req1_ready), 36'(e1));
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                e.id  = req1_valid && req1_ready;
                e.exp = e.id ? expect_of(req1_a, req1_b, req1_op) : expect_of(req0_a, req0_b, req0_op);
                e.lat = e.id ? wait_of(req1_op) : wait_of(req0_op);
                e.acc = cyc;
                q.push_back(e);
                inflight = 1'b1;
                seen     = 1'b0;
                last_win = e.id;
                if (e.id) hs1++; else hs0++;
            end
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", 36'(rsp_valid), 36'd0);
                end else begin
                    if (!prev_rv) chk("rsp_latency", 36'(cyc - q[0].acc), 36'(1 + q[0].lat));
                    seen = 1'b1;
                    chk("rsp_id", 36'(rsp_id), 36'(q[0].id));
                    chk("rsp_data", {rsp_err, rsp_flags, rsp_hi, rsp_out}, q[0].exp);
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        inflight = 1'b0;
                    end
                end
            end else if (inflight && !seen && q.size() > 0 && (cyc - q[0].acc) > 40) begin
                chk("rsp_timeout", 36'(rsp_valid), 36'd1);
                q.delete();
                inflight = 1'b0;
            end
            prev_rv = rsp_valid && !rsp_ready;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        #1;
        chk("reset_outputs",
            36'({busy, rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_out, alu_ins, req0_ready, req1_ready}), 36'd0);
        chk("reset_alu_ops", 36'({alu_a, alu_b}), 36'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic issue(input logic id, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op, output int acc);
        @(posedge clk);
        #1;
        if (id) begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
        else    begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
        acc = -1;
        for (int n = 0; n < 50 && acc < 0; n++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) acc = cyc;
        end
        if (acc < 0) chk("issue_timeout", 36'(id ? req1_ready : req0_ready), 36'd1);
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int t, output logic [36:0] snap);
        t = -1;
        for (int n = 0; n < 60 && t < 0; n++) begin
            @(negedge clk);
            if (rsp_valid) t = cyc;
        end
        snap = {rsp_id, rsp_err, rsp_flags, rsp_hi, rsp_out};
        if (t < 0) chk("wait_rsp_timeout", 36'(rsp_valid), 36'd1);
    endtask

    function automatic logic [3:0] rand_op();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 16) return 4'(r);
        return 4'($urandom_range(1, 9));
    endfunction

    function automatic logic [15:0] rand_val();
        if ($urandom_range(0, 3) == 0) return 16'($urandom_range(0, 7));
        return 16'($urandom);
    endfunction

    initial begin
        int acc, t, h0, h1;
        logic [36:0] s;
        logic [3:0] ord;

        // Directed: add, sub, mul
        do_reset();
        rsp_ready = 1'b1;
        issue(1'b0, 16'd3, 16'd511, 4'd1, acc);
        wait_rsp(t, s);
        chk("add_out", 36'(s[15:0]), 36'd514);
        chk("add_id", 36'(s[36]), 36'd0);
        chk("add_latency", 36'(t - acc), 36'd2);

        issue(1'b1, 16'd3, 16'd511, 4'd2, acc);
        wait_rsp(t, s);
        chk("sub_out", 36'(s[15:0]), 36'hFE04);
        chk("sub_id", 36'(s[36]), 36'd1);

        issue(1'b0, 16'd3, 16'd511, 4'd3, acc);
        wait_rsp(t, s);
        chk("mul_out", 36'(s[15:0]), 36'd1533);
        chk("mul_hi", 36'(s[31:16]), 36'd0);
        chk("mul_latency", 36'(t - acc), 36'd5);

        // Both requesters valid continuously: grants alternate starting at req0
        do_reset();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req0_a = 16'h00F0; req0_b = 16'h0F00; req0_op = 4'd5; req0_valid = 1'b1;
        req1_a = 16'h1234; req1_b = 16'h0001; req1_op = 4'd5; req1_valid = 1'b1;
        ord = '0;
        h0 = 0;
        for (int n = 0; n < 80 && h0 < 4; n++) begin
            @(negedge clk);
            if (req0_ready) begin ord = {ord[2:0], 1'b0}; h0++; end
            else if (req1_ready) begin ord = {ord[2:0], 1'b1}; h0++; end
        end
        chk("grant_count", 36'(h0), 36'd4);
        chk("grant_order", 36'(ord), 36'b0101);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (10) @(posedge clk);

        // Response back-pressure with an illegal op
        rsp_ready = 1'b0;
        issue(1'b0, 16'h1234, 16'h5678, 4'd12, acc);
        wait_rsp(t, s);
        chk("ill_err", 36'(s[35]), 36'd1);
        chk("ill_result", 36'(s[34:0]), 36'd0);
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_op = 4'd1;
        req1_valid = 1'b1; req1_op = 4'd1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("stall_stable", 36'({rsp_id, rsp_err, rsp_flags, rsp_hi, rsp_out}), 36'(s));
            chk("stall_valid", 36'(rsp_valid), 36'd1);
            chk("stall_ready", 36'({req0_ready, req1_ready}), 36'd0);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (4) @(posedge clk);

        // Reset in the middle of a divide
        issue(1'b0, 16'd100, 16'd7, 4'd4, acc);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", 36'(busy), 36'd0);
        chk("midreset_rsp_valid", 36'(rsp_valid), 36'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("no_rsp_after_reset", 36'(rsp_valid), 36'd0);
        end

        // Randomized traffic
        h0 = hs0;
        h1 = hs1;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            if (!req0_valid || hs0 != h0) begin
                h0 = hs0;
                req0_valid = ($urandom_range(0, 9) < 6);
                req0_a = rand_val(); req0_b = rand_val(); req0_op = rand_op();
            end
            if (!req1_valid || hs1 != h1) begin
                h1 = hs1;
                req1_valid = ($urandom_range(0, 9) < 6);
                req1_a = rand_val(); req1_b = rand_val(); req1_op = rand_op();
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (30) @(posedge clk);
        chk("scoreboard_drained", 36'(q.size()), 36'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
